state_pio_bank: RTL and testbench
=================================

# state_pio_bank

Parametrised, coherent-snapshot register bank between the game-logic fabric and the Nios II Avalon-MM bus; successor to the per-signal 32-bit PIO exports (positions, velocities, aim, keycode, hex, LEDs). N input channels are captured together on each frame strobe, so software never reads a position from one frame and a velocity from another. It also provides N software-written output registers, frame and dropped-frame counters, and an optional new-frame interrupt.

## Interface
- N_CH, default 8: snapshot input channels, 1..48.
- DATA_W, default 32: input channel width, 1..32, zero-extended on read.
- N_OUT, default 2: output registers, 1..12.
- OUT_W, default 16: output register width, 1..32.
- clk_50_clk  in  1  system clock, 50 MHz.
- reset_50_reset_n  in  1  reset, synchronous, active-low.
- avs_address  in  6  word address.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  read data valid.
- ch_in  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- frame_strobe  in  1  level input (e.g. VGA vsync); a rising edge marks a frame.
- out_data  out  N_OUT*OUT_W  output register j occupies bits [j*OUT_W +: OUT_W].
- irq  out  1  level interrupt request.

## Operation
- Register map (word addresses):
  - 0x00 CTRL, RW: bit0 FREEZE, bit1 IRQ_EN.
  - 0x01 STATUS: bit0 NEW_FRAME, sticky, write-1-to-clear; bits 15:8 DROP_CNT, read-only.
  - 0x02 FRAME_CNT, RO: 32 bits, wraps at 2^32.
  - 0x04..0x04+N_OUT-1 OUT[j], RW: OUT_W bits, upper bits read 0.
  - 0x10..0x10+N_CH-1 CH[i], RO: snapshot values.
  - Unmapped addresses read 0; writes to RO or unmapped addresses are ignored.
- Frame event: frame_strobe is registered and edge-detected; an event fires on the cycle after the first high sample following a low sample.
- On a frame event:
  - FRAME_CNT increments.
  - If FREEZE=0: all N_CH channels load into the shadow bank in the same cycle, and NEW_FRAME is set.
  - If FREEZE=1: the shadow bank holds its value, and DROP_CNT increments, saturating at 255.
- Clearing FREEZE does not trigger a catch-up snapshot; the next frame event does.
- Writing STATUS with bit8 set clears DROP_CNT.
- irq = NEW_FRAME & IRQ_EN (see Configuration).
- Simultaneous events:
  - Frame-event set of NEW_FRAME and W1C clear in the same cycle: set wins.
  - Saturating DROP_CNT increment and DROP_CNT clear in the same cycle: clear wins; the result is 0.
  - A read of CH[i] in the cycle a snapshot loads returns the pre-load value.

## Timing
- Read latency is fixed at 1: avs_readdatavalid pulses the cycle after avs_read. No waitrequest; back-to-back reads are accepted every cycle.
- Writes take effect on the following edge. out_data updates one cycle after the write.
- Snapshot visibility: shadow bank valid 2 cycles after the frame_strobe rising edge is sampled. irq asserts in the same cycle.
- Reset values:
  - avs_readdata=0, avs_readdatavalid=0, irq=0, out_data=0.
  - CTRL=0, STATUS=0, FRAME_CNT=0, shadow bank=0.
  - Edge-detector register=1, so a strobe held high through reset creates no event.
- Reset mid-read: a pending readdatavalid is dropped.
- avs_read and avs_write asserted together: the write is performed and the read returns the pre-write value.

## Configuration
- STATE_PIO_IRQ_EN defined:
  - IRQ_EN bit is implemented.
  - irq behaves as in Operation.
- STATE_PIO_IRQ_EN undefined:
  - irq is tied to 0.
  - CTRL bit1 is not stored and reads 0.
  - NEW_FRAME still works for polling.

## Structure
- Package state_pio_pkg holds:
  - address constants ADDR_CTRL, ADDR_STATUS, ADDR_FRAME_CNT, ADDR_OUT_BASE, ADDR_CH_BASE.
  - CTRL/STATUS bit-position constants.
  - DROP_CNT_MAX=255.
- One sub-module, state_pio_edge: the registered rising-edge detector with reset value 1.
- Decode, register file and counters live in the top module.

## Test plan
- Reset, then read 0x00/0x01/0x02/0x10 -> all return 0 with readdatavalid exactly 1 cycle later; irq=0.
- ch_in[0]=0x0000_1234, ch_in[1]=0xFFFF_0001, one strobe pulse, then change ch_in -> CH0=0x1234, CH1=0xFFFF0001, FRAME_CNT=1, STATUS bit0=1.
- CTRL=0x1 (freeze), 3 strobe pulses -> CH unchanged, FRAME_CNT=+3, DROP_CNT=3; 300 pulses -> DROP_CNT=255; write STATUS=0x100 -> DROP_CNT=0.
- With STATE_PIO_IRQ_EN defined: CTRL=0x2, strobe pulse -> irq=1 two cycles after the edge. Write STATUS=0x1 in the same cycle as the next frame event -> NEW_FRAME stays 1.
- Write OUT0=0xBEEF (OUT_W=16) -> out_data[15:0]=0xBEEF next cycle, read back 0x0000BEEF. Read 0x3F with N_CH=8 -> 0; write 0x02 -> FRAME_CNT unchanged.

Source files
------------

// File: rtl/state_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : state_pio_pkg
// Description : Shared constants for the state_pio_bank register slice:
//               Avalon word addresses, CTRL/STATUS bit positions, the
//               dropped-frame counter ceiling and a STATUS word packer.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package state_pio_pkg;

   // Avalon word-address width
   localparam int ADDR_W = 6;

   // Register map (word addresses)
   localparam logic [ADDR_W-1:0] ADDR_CTRL      = 6'h00;
   localparam logic [ADDR_W-1:0] ADDR_STATUS    = 6'h01;
   localparam logic [ADDR_W-1:0] ADDR_FRAME_CNT = 6'h02;
   localparam logic [ADDR_W-1:0] ADDR_OUT_BASE  = 6'h04;
   localparam logic [ADDR_W-1:0] ADDR_CH_BASE   = 6'h10;

   // CTRL bit positions
   localparam int CTRL_FREEZE_BIT = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;

   // STATUS bit positions
   localparam int STATUS_NEW_FRAME_BIT = 0;   // sticky, write-1-to-clear
   localparam int STATUS_DROP_LSB      = 8;   // DROP_CNT occupies [15:8]
   localparam int STATUS_DROP_CLR_BIT  = 8;   // writing 1 here zeroes DROP_CNT

   // Dropped-frame counter saturates here
   localparam logic [7:0] DROP_CNT_MAX = 8'd255;

   // Assemble the 32-bit STATUS read word
   function automatic logic [31:0] status_word(input logic       new_frame,
                                               input logic [7:0] drop_cnt);
      logic [31:0] w;
      w = '0;
      w[STATUS_NEW_FRAME_BIT]    = new_frame;
      w[STATUS_DROP_LSB +: 8]    = drop_cnt;
      return w;
   endfunction

endpackage : state_pio_pkg
`default_nettype wire

// File: rtl/state_pio_edge.sv
`default_nettype none
// ============================================================================
// Module      : state_pio_edge
// Description : Registered rising-edge detector for the frame strobe.
//               The strobe is sampled once, compared with its previous
//               sample, and the result is registered into a one-cycle
//               pulse. Both sample registers reset to 1 so a strobe that
//               is already high when reset releases produces no event.
// Ports       : clk         in   system clock
//               rst_n       in   synchronous active-low reset
//               i_strobe    in   level strobe (e.g. vsync)
//               o_frame_evt out  one-cycle pulse, the cycle after the first
//                                high sample that follows a low sample
// Revision    : 1.0  initial release
// ============================================================================
module state_pio_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_strobe,
   output logic o_frame_evt
);

   logic r_sample;     // current strobe sample
   logic r_sample_d;   // previous strobe sample
   logic r_evt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sample   <= 1'b1;
         r_sample_d <= 1'b1;
         r_evt      <= 1'b0;
      end else begin
         r_sample   <= i_strobe;
         r_sample_d <= r_sample;
         r_evt      <= r_sample & ~r_sample_d;
      end
   end

   assign o_frame_evt = r_evt;

endmodule : state_pio_edge
`default_nettype wire

// File: rtl/state_pio_bank.sv
`default_nettype none
// ============================================================================
// Module      : state_pio_bank
// Description : Coherent-snapshot register bank on an Avalon-MM slave.
//               All N_CH input channels are captured into a shadow bank in
//               the same cycle on each frame event, so software always reads
//               a self-consistent set. Also holds N_OUT software-written
//               output registers, a free-running frame counter, a saturating
//               dropped-frame counter (frames seen while frozen) and a sticky
//               NEW_FRAME flag.
//               Optional feature macro: STATE_PIO_IRQ_EN
//                 defined   -> CTRL.IRQ_EN stored, irq = NEW_FRAME & IRQ_EN
//                 undefined -> CTRL bit1 reads 0, irq tied low
// Ports       : clk_50_clk         in   50 MHz system clock
//               reset_50_reset_n   in   synchronous active-low reset
//               avs_address        in   6-bit word address
//               avs_read/avs_write in   bus strobes
//               avs_writedata      in   32-bit write data
//               avs_readdata       out  32-bit read data (latency 1)
//               avs_readdatavalid  out  pulses the cycle after avs_read
//               ch_in              in   N_CH x DATA_W snapshot inputs
//               frame_strobe       in   level frame strobe
//               out_data           out  N_OUT x OUT_W output registers
//               irq                out  level interrupt
// Revision    : 1.0  initial release
// ============================================================================
module state_pio_bank
   import state_pio_pkg::*;
#(
   parameter int N_CH   = 8,
   parameter int DATA_W = 32,
   parameter int N_OUT  = 2,
   parameter int OUT_W  = 16
) (
   input  logic                    clk_50_clk,
   input  logic                    reset_50_reset_n,
   input  logic [ADDR_W-1:0]       avs_address,
   input  logic                    avs_read,
   input  logic                    avs_write,
   input  logic [31:0]             avs_writedata,
   output logic [31:0]             avs_readdata,
   output logic                    avs_readdatavalid,
   input  logic [N_CH*DATA_W-1:0]  ch_in,
   input  logic                    frame_strobe,
   output logic [N_OUT*OUT_W-1:0]  out_data,
   output logic                    irq
);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic              r_freeze;
`ifdef STATE_PIO_IRQ_EN
   logic              r_irq_en;
`endif
   logic              r_new_frame;
   logic [7:0]        r_drop_cnt;
   logic [31:0]       r_frame_cnt;
   logic [DATA_W-1:0] r_shadow [N_CH];
   logic [OUT_W-1:0]  r_out    [N_OUT];
   logic [31:0]       r_readdata;
   logic              r_readdatavalid;

   logic              w_frame_evt;
   logic              w_wr_ctrl;
   logic              w_wr_status;
   logic              w_new_frame_clr;
   logic              w_drop_clr;
   logic              w_snap;
   logic [31:0]       w_rdata;
   logic              w_unused_wdata;

   // Only a handful of write-data bits land in storage
   assign w_unused_wdata = ^avs_writedata;

   // ------------------------------------------------------------------
   // Frame event
   // ------------------------------------------------------------------
   state_pio_edge u_edge (
      .clk         (clk_50_clk),
      .rst_n       (reset_50_reset_n),
      .i_strobe    (frame_strobe),
      .o_frame_evt (w_frame_evt)
   );

   // A frame event either snapshots (running) or is counted as dropped
   assign w_snap = w_frame_evt & ~r_freeze;

   // ------------------------------------------------------------------
   // Write decode
   // ------------------------------------------------------------------
   assign w_wr_ctrl       = avs_write && (avs_address == ADDR_CTRL);
   assign w_wr_status     = avs_write && (avs_address == ADDR_STATUS);
   assign w_new_frame_clr = w_wr_status && avs_writedata[STATUS_NEW_FRAME_BIT];
   assign w_drop_clr      = w_wr_status && avs_writedata[STATUS_DROP_CLR_BIT];

   // ------------------------------------------------------------------
   // CTRL
   // ------------------------------------------------------------------
   always_ff @(posedge clk_50_clk) begin
      if (!reset_50_reset_n) begin
         r_freeze <= 1'b0;
`ifdef STATE_PIO_IRQ_EN
         r_irq_en <= 1'b0;
`endif
      end else if (w_wr_ctrl) begin
         r_freeze <= avs_writedata[CTRL_FREEZE_BIT];
`ifdef STATE_PIO_IRQ_EN
         r_irq_en <= avs_writedata[CTRL_IRQ_EN_BIT];
`endif
      end
   end

   // ------------------------------------------------------------------
   // STATUS and FRAME_CNT
   // ------------------------------------------------------------------
   always_ff @(posedge clk_50_clk) begin
      if (!reset_50_reset_n) begin
         r_new_frame <= 1'b0;
         r_drop_cnt  <= '0;
         r_frame_cnt <= '0;
      end else begin
         // A fresh snapshot outranks a concurrent software clear so the
         // new frame is never lost
         if (w_snap)
            r_new_frame <= 1'b1;
         else if (w_new_frame_clr)
            r_new_frame <= 1'b0;

         // Software clear outranks a concurrent dropped-frame increment
         if (w_drop_clr)
            r_drop_cnt <= '0;
         else if (w_frame_evt && r_freeze && (r_drop_cnt != DROP_CNT_MAX))
            r_drop_cnt <= r_drop_cnt + 8'd1;

         if (w_frame_evt)
            r_frame_cnt <= r_frame_cnt + 32'd1;
      end
   end

   // ------------------------------------------------------------------
   // Shadow bank: every channel loads on the same edge
   // ------------------------------------------------------------------
   always_ff @(posedge clk_50_clk) begin
      if (!reset_50_reset_n) begin
         for (int i = 0; i < N_CH; i++)
            r_shadow[i] <= '0;
      end else if (w_snap) begin
         for (int i = 0; i < N_CH; i++)
            r_shadow[i] <= ch_in[i*DATA_W +: DATA_W];
      end
   end

   // ------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_50_clk) begin
      if (!reset_50_reset_n) begin
         for (int j = 0; j < N_OUT; j++)
            r_out[j] <= '0;
      end else if (avs_write) begin
         for (int j = 0; j < N_OUT; j++)
            if (avs_address == (ADDR_OUT_BASE + ADDR_W'(j)))
               r_out[j] <= avs_writedata[OUT_W-1:0];
      end
   end

   generate
      for (genvar j = 0; j < N_OUT; j++) begin : g_out_pack
         assign out_data[j*OUT_W +: OUT_W] = r_out[j];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Read mux. Sampled from current register state, so a read that
   // coincides with a write or a snapshot load returns the old value.
   // ------------------------------------------------------------------
   always_comb begin
      w_rdata = '0;
      if (avs_address == ADDR_CTRL) begin
         w_rdata[CTRL_FREEZE_BIT] = r_freeze;
`ifdef STATE_PIO_IRQ_EN
         w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
`endif
      end
      if (avs_address == ADDR_STATUS)
         w_rdata = status_word(r_new_frame, r_drop_cnt);
      if (avs_address == ADDR_FRAME_CNT)
         w_rdata = r_frame_cnt;
      for (int j = 0; j < N_OUT; j++)
         if (avs_address == (ADDR_OUT_BASE + ADDR_W'(j)))
            w_rdata[OUT_W-1:0] = r_out[j];
      for (int i = 0; i < N_CH; i++)
         if (avs_address == (ADDR_CH_BASE + ADDR_W'(i)))
            w_rdata[DATA_W-1:0] = r_shadow[i];
   end

   // Fixed one-cycle read latency; reset drops any pending valid
   always_ff @(posedge clk_50_clk) begin
      if (!reset_50_reset_n) begin
         r_readdata      <= '0;
         r_readdatavalid <= 1'b0;
      end else begin
         r_readdatavalid <= avs_read;
         if (avs_read)
            r_readdata <= w_rdata;
      end
   end

   assign avs_readdata      = r_readdata;
   assign avs_readdatavalid = r_readdatavalid;

   // ------------------------------------------------------------------
   // Interrupt
   // ------------------------------------------------------------------
`ifdef STATE_PIO_IRQ_EN
   assign irq = r_new_frame & r_irq_en;
`else
   assign irq = 1'b0;
`endif

endmodule : state_pio_bank
`default_nettype wire

// File: tb/tb_state_pio_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_state_pio_bank
// Description : Self-checking bench for state_pio_bank. Reads push their
//               expected data onto a queue; a monitor pops and compares when
//               avs_readdatavalid arrives, and checks the 1-cycle latency.
// Revision    : 1.0  initial release
// ============================================================================
module tb_state_pio_bank;

   localparam int N_CH   = 8;
   localparam int DATA_W = 32;
   localparam int N_OUT  = 2;
   localparam int OUT_W  = 16;

`ifdef STATE_PIO_IRQ_EN
   localparam logic        IRQ_ON   = 1'b1;
   localparam logic [31:0] CTRL_IRQ = 32'h2;
`else
   localparam logic        IRQ_ON   = 1'b0;
   localparam logic [31:0] CTRL_IRQ = 32'h0;
`endif

   logic                   clk;
   logic                   reset_n;
   logic [5:0]             avs_address;
   logic                   avs_read;
   logic                   avs_write;
   logic [31:0]            avs_writedata;
   logic [31:0]            avs_readdata;
   logic                   avs_readdatavalid;
   logic [N_CH*DATA_W-1:0] ch_in;
   logic                   frame_strobe;
   logic [N_OUT*OUT_W-1:0] out_data;
   logic                   irq;

   state_pio_bank #(
      .N_CH   (N_CH),
      .DATA_W (DATA_W),
      .N_OUT  (N_OUT),
      .OUT_W  (OUT_W)
   ) dut (
      .clk_50_clk        (clk),
      .reset_50_reset_n  (reset_n),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .ch_in             (ch_in),
      .frame_strobe      (frame_strobe),
      .out_data          (out_data),
      .irq               (irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q [$];
   string       tag_q [$];
   logic        rd_prev = 1'b0;
   int          exp_frames = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Scoreboard monitor
   always @(posedge clk) rd_prev <= avs_read & reset_n;

   always @(negedge clk) begin
      if (rd_prev || avs_readdatavalid)
         check("rvalid_latency", {31'b0, avs_readdatavalid}, {31'b0, rd_prev});
      if (avs_readdatavalid) begin
         if (exp_q.size() == 0)
            check("rvalid_unexpected", {31'b0, avs_readdatavalid}, 32'd0);
         else
            check(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- bus / stimulus tasks (entered at a negedge) --------
   task automatic bus_write(input logic [5:0] addr, input logic [31:0] data);
      avs_address = addr; avs_writedata = data; avs_write = 1'b1;
      @(negedge clk);
      avs_write = 1'b0;
   endtask

   task automatic bus_read(input string tag, input logic [5:0] addr, input logic [31:0] exp);
      avs_address = addr; avs_read = 1'b1;
      exp_q.push_back(exp); tag_q.push_back(tag);
      @(negedge clk);
      avs_read = 1'b0;
   endtask

   task automatic pulse();
      frame_strobe = 1'b1;
      repeat (2) @(negedge clk);
      frame_strobe = 1'b0;
      repeat (2) @(negedge clk);
      exp_frames++;
   endtask

   // Strobe pulse with a bus write landing on the very edge the frame
   // event acts on (the edge two after the strobe is first sampled high)
   task automatic pulse_with_write(input logic [5:0] addr, input logic [31:0] data);
      frame_strobe = 1'b1;
      repeat (2) @(negedge clk);
      avs_address = addr; avs_writedata = data; avs_write = 1'b1;
      @(negedge clk);
      avs_write = 1'b0; frame_strobe = 1'b0;
      repeat (2) @(negedge clk);
      exp_frames++;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
      avs_writedata = '0; ch_in = '0; frame_strobe = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_irq",      {31'b0, irq}, 32'd0);
      check("rst_rvalid",   {31'b0, avs_readdatavalid}, 32'd0);
      check("rst_rdata",    avs_readdata, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      bus_read("rst_ctrl",   6'h00, 32'd0);
      bus_read("rst_status", 6'h01, 32'd0);
      bus_read("rst_frames", 6'h02, 32'd0);
      bus_read("rst_ch0",    6'h10, 32'd0);
      repeat (2) @(negedge clk);

      // Basic snapshot, inputs change afterwards
      ch_in[0*DATA_W +: DATA_W] = 32'h0000_1234;
      ch_in[1*DATA_W +: DATA_W] = 32'hFFFF_0001;
      pulse();
      ch_in[0*DATA_W +: DATA_W] = 32'h5555_AAAA;
      ch_in[1*DATA_W +: DATA_W] = 32'h0BAD_F00D;
      ch_in[2*DATA_W +: DATA_W] = 32'h0000_0777;
      @(negedge clk);
      bus_read("snap_ch0",    6'h10, 32'h0000_1234);
      bus_read("snap_ch1",    6'h11, 32'hFFFF_0001);
      bus_read("snap_ch2",    6'h12, 32'h0000_0000);
      bus_read("snap_frames", 6'h02, 32'(exp_frames));
      bus_read("snap_status", 6'h01, 32'h0000_0001);
      bus_write(6'h01, 32'h1);
      bus_read("w1c_status",  6'h01, 32'h0000_0000);

      // Freeze: bank holds, drops counted and saturate
      bus_write(6'h00, 32'h1);
      repeat (3) pulse();
      bus_read("frz_ctrl",   6'h00, 32'h1);
      bus_read("frz_ch0",    6'h10, 32'h0000_1234);
      bus_read("frz_frames", 6'h02, 32'(exp_frames));
      bus_read("frz_drop3",  6'h01, 32'h0000_0300);
      repeat (300) pulse();
      bus_read("drop_sat",   6'h01, 32'h0000_FF00);
      bus_read("frz_frames2", 6'h02, 32'(exp_frames));
      bus_write(6'h01, 32'h100);
      bus_read("drop_clr",   6'h01, 32'h0000_0000);

      // Unfreeze: no catch-up snapshot until the next frame
      bus_write(6'h00, 32'h0);
      bus_read("unfrz_ch0",  6'h10, 32'h0000_1234);
      pulse();
      bus_read("unfrz_ch0b", 6'h10, 32'h5555_AAAA);
      bus_read("unfrz_ch2",  6'h12, 32'h0000_0777);
      bus_write(6'h01, 32'h1);

      // Interrupt enable and snapshot latency
      bus_write(6'h00, 32'h2);
      bus_read("ctrl_irq_bit", 6'h00, CTRL_IRQ);
      ch_in[3*DATA_W +: DATA_W] = 32'hCAFE_0003;
      frame_strobe = 1'b1;
      repeat (2) @(negedge clk);
      check("irq_early", {31'b0, irq}, 32'd0);
      @(negedge clk);
      check("irq_set",   {31'b0, irq}, {31'b0, IRQ_ON});
      frame_strobe = 1'b0;
      repeat (2) @(negedge clk);
      exp_frames++;
      bus_read("irq_ch3",    6'h13, 32'hCAFE_0003);
      bus_read("poll_status", 6'h01, 32'h0000_0001);

      // W1C colliding with a frame event: set wins
      pulse_with_write(6'h01, 32'h1);
      bus_read("set_wins", 6'h01, 32'h0000_0001);
      check("irq_kept", {31'b0, irq}, {31'b0, IRQ_ON});

      // Drop increment colliding with drop clear: clear wins
      bus_write(6'h00, 32'h1);
      pulse();
      bus_read("drop_one", 6'h01, 32'h0000_0101);
      pulse_with_write(6'h01, 32'h100);
      bus_read("clr_wins", 6'h01, 32'h0000_0001);
      bus_write(6'h00, 32'h0);

      // Output registers
      bus_write(6'h04, 32'h0000_BEEF);
      check("out0_next", {16'b0, out_data[15:0]}, 32'h0000_BEEF);
      bus_write(6'h05, 32'h1234_5678);
      check("out_data_all", out_data, 32'h5678_BEEF);
      bus_read("out0_rd", 6'h04, 32'h0000_BEEF);
      bus_read("out1_rd", 6'h05, 32'h0000_5678);

      // Unmapped and read-only
      bus_read("unmap_3f", 6'h3F, 32'd0);
      bus_read("unmap_18", 6'h18, 32'd0);
      bus_read("unmap_06", 6'h06, 32'd0);
      bus_write(6'h02, 32'hDEAD_0000);
      bus_write(6'h3F, 32'hFFFF_FFFF);
      bus_read("ro_frames", 6'h02, 32'(exp_frames));

      // Simultaneous read and write: read returns the old value
      avs_address = 6'h04; avs_writedata = 32'h0000_1111;
      avs_read = 1'b1; avs_write = 1'b1;
      exp_q.push_back(32'h0000_BEEF); tag_q.push_back("rw_old");
      @(negedge clk);
      avs_read = 1'b0; avs_write = 1'b0;
      bus_read("rw_new", 6'h04, 32'h0000_1111);
      repeat (2) @(negedge clk);

      // Reset together with a read: no valid, registers cleared
      avs_address = 6'h02; avs_read = 1'b1; reset_n = 1'b0;
      @(negedge clk);
      avs_read = 1'b0;
      check("rst_drop_valid", {31'b0, avs_readdatavalid}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst2_out_data", out_data, 32'd0);
      bus_read("rst2_frames", 6'h02, 32'd0);
      bus_read("rst2_ch0",    6'h10, 32'd0);

      repeat (4) @(negedge clk);
      check("rq_drain", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_state_pio_bank
`default_nettype wire
